aes128_dec: RTL

Iterative AES-128 decryption core with a 32-bit (one column per cycle) datapath. It accepts a 128-bit ciphertext block and the 128-bit cipher key, which is the same key given to the encryption core. It expands that key forward to the round-10 key, then decrypts while deriving earlier round keys with the inverse key schedule on the fly. It pairs with the encryption core as the receive-side block and shares its clock, `ce` gating and `done` convention.

---
 rtl/aes128_dec.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/aes128_dec.sv
// aes128_dec: iterative AES-128 decryptor, one column per cycle; optional rk10 key cache under AES_DEC_KEYCACHE_EN
module aes128_dec (
  input  logic         clock,
  input  logic         reset,
  input  logic         ce,
  input  logic         start,
  input  logic [127:0] data_in,
  input  logic [127:0] key,
  output logic [127:0] data_out,
  output logic         done
);
  localparam logic [1:0] IDLE = 2'd0, KEYEXP = 2'd1, DEC = 2'd2;
  logic [1:0] st_q, st_d;
  logic [5:0] cnt_q, cnt_d;
  logic [3:0] rnd_q, rnd_d;
  logic [1:0] stp_q, stp_d;
  logic [127:0] state_q, state_d, key_q, key_d, s_in, key_fwd, key_inv, hit_rk;
  logic [31:0] col, kw, ark, dcol, sw_in, sw_out, w3n;
  logic accept, hit, kx_last;
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xt(t);
    end
    return p;
  endfunction
  // multiplicative inverse as x^254; maps 0 to 0 as the S-box requires
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] p, t;
    p = 8'h01;
    t = x;
    for (int i = 1; i < 8; i++) begin
      t = gmul(t, t);
      p = gmul(p, t);
    end
    return p;
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [7:0] isbox(input logic [7:0] x);
    return ginv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
  endfunction
  function automatic logic [31:0] inv_mix(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction
  function automatic logic [127:0] inv_shift(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction
  function automatic logic [7:0] rcon(input logic [3:0] i);
    return i < 4'd8 ? 8'h01 << i : i == 4'd8 ? 8'h1b : 8'h36;
  endfunction
  assign accept  = ce && st_q == IDLE && start;
  assign kx_last = st_q == KEYEXP && cnt_q == 6'd39;
`ifdef AES_DEC_KEYCACHE_EN
  logic [127:0] ck_q, ck_d, crk_q, crk_d;
  logic cv_q, cv_d;
  assign hit    = cv_q && key == ck_q;
  assign hit_rk = crk_q;
  always_comb begin
    ck_d  = accept && !hit ? key : ck_q;
    crk_d = ce && kx_last ? key_fwd : crk_q;
    cv_d  = accept && !hit ? 1'b0 : ce && kx_last ? 1'b1 : cv_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      ck_q  <= '0;
      crk_q <= '0;
      cv_q  <= 1'b0;
    end else begin
      ck_q  <= ck_d;
      crk_q <= crk_d;
      cv_q  <= cv_d;
    end
  end
`else
  assign hit    = 1'b0;
  assign hit_rk = '0;
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      st_q    <= IDLE;
      cnt_q   <= '0;
      rnd_q   <= '0;
      stp_q   <= '0;
      state_q <= '0;
      key_q   <= '0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      rnd_q   <= rnd_d;
      stp_q   <= stp_d;
      state_q <= state_d;
      key_q   <= key_d;
    end
  end
  always_comb begin
    st_d = !ce ? st_q
         : st_q == IDLE ? (start ? (hit ? DEC : KEYEXP) : IDLE)
         : st_q == KEYEXP ? (cnt_q == 6'd39 ? DEC : KEYEXP)
         : (rnd_q == 4'd10 && stp_q == 2'd3 ? IDLE : DEC);
  end
  always_comb begin
    done     = st_q == IDLE;
    data_out = state_q;
  end
  // the forward S-boxes serve key expansion in KEYEXP and the inverse schedule in DEC
  always_comb begin
    sw_in   = st_q == KEYEXP ? key_q[31:0] : key_q[31:0] ^ key_q[63:32];
    sw_out  = {sbox(sw_in[23:16]), sbox(sw_in[15:8]), sbox(sw_in[7:0]), sbox(sw_in[31:24])};
    key_fwd = {key_q[95:0], key_q[127:96] ^ (cnt_q[1:0] == 2'd0 ? sw_out ^ {rcon(cnt_q[5:2]), 24'h0} : key_q[31:0])};
    w3n     = key_q[31:0] ^ key_q[63:32];
    key_inv = {key_q[127:96] ^ sw_out ^ {rcon(4'd9 - rnd_q), 24'h0}, key_q[95:64] ^ key_q[127:96], key_q[63:32] ^ key_q[95:64], w3n};
    s_in    = rnd_q != 4'd0 && stp_q == 2'd0 ? inv_shift(state_q) : state_q;
    col     = s_in[127-32*stp_q -: 32];
    kw      = key_q[127-32*stp_q -: 32];
    ark     = (rnd_q == 4'd0 ? col : {isbox(col[31:24]), isbox(col[23:16]), isbox(col[15:8]), isbox(col[7:0])}) ^ kw;
    dcol    = rnd_q == 4'd0 || rnd_q == 4'd10 ? ark : inv_mix(ark);
    cnt_d   = !ce ? cnt_q : st_q == KEYEXP && cnt_q != 6'd39 ? cnt_q + 6'd1 : 6'd0;
    stp_d   = !ce ? stp_q : st_q == DEC ? stp_q + 2'd1 : 2'd0;
    rnd_d   = !ce ? rnd_q : st_q != DEC ? 4'd0 : stp_q != 2'd3 ? rnd_q : rnd_q == 4'd10 ? 4'd0 : rnd_q + 4'd1;
    state_d = state_q;
    if (accept) state_d = data_in;
    else if (ce && st_q == DEC) begin
      state_d = s_in;
      state_d[127-32*stp_q -: 32] = dcol;
    end
    key_d = accept ? (hit ? hit_rk : key)
          : ce && st_q == KEYEXP ? key_fwd
          : ce && st_q == DEC && stp_q == 2'd3 && rnd_q != 4'd10 ? key_inv
          : key_q;
  end
endmodule
